// File: rtl/cobs_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : cobs_uart_rx
// Brief    : 8N1 UART receiver feeding a COBS decoder with last-byte lookahead.
// Revision : 1.0 - initial release
// ============================================================================
module cobs_uart_rx #(
  parameter int CLK_HZ    = 27000000,
  parameter int BAUD      = 115200,
  parameter int MAX_FRAME = 256,
  parameter int IDX_W     = $clog2(MAX_FRAME)
) (
  input  logic             I_clk,
  input  logic             I_reset_n,
  input  logic             rxd,
  output logic [7:0]       O_data,
  output logic             O_valid,
  output logic [IDX_W-1:0] O_idx,
  output logic             O_first,
  output logic             O_last,
  output logic             O_frame_ok,
  output logic [IDX_W:0]   O_len,
  output logic             O_err,
  output logic [1:0]       O_err_code
);
  localparam int c_div   = CLK_HZ / BAUD;
  localparam int c_cnt_w = $clog2(c_div + 1);
  localparam int c_len_w = IDX_W + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(c_div - 1);
  localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(c_div / 2 - 1);
  localparam logic [c_len_w-1:0] c_max  = c_len_w'(MAX_FRAME);

  if (c_div < 16) begin : g_div_check
    $error("cobs_uart_rx: CLK_HZ/BAUD must be at least 16");
  end
  if (MAX_FRAME < 2) begin : g_frame_check
    $error("cobs_uart_rx: MAX_FRAME must be at least 2");
  end

  // ---------------- UART front end ----------------
  typedef enum logic [2:0] {U_IDLE, U_START, U_BITS, U_STOP, U_WAIT} uart_state_t;
  uart_state_t        r_ustate, w_ustate;
  logic [1:0]         r_sync;
  logic               r_rxd_prev;
  logic [c_cnt_w-1:0] r_cnt, w_cnt;
  logic [2:0]         r_bitn, w_bitn;
  logic [7:0]         r_shift, w_shift;
  logic               w_rxd, w_rx_stb, w_rx_ferr;

  assign w_rxd = r_sync[1];

  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      r_sync     <= 2'b11;
      r_rxd_prev <= 1'b1;
      r_ustate   <= U_IDLE;
      r_cnt      <= '0;
      r_bitn     <= 3'd0;
      r_shift    <= 8'h00;
    end else begin
      r_sync     <= {r_sync[0], rxd};
      r_rxd_prev <= w_rxd;
      r_ustate   <= w_ustate;
      r_cnt      <= w_cnt;
      r_bitn     <= w_bitn;
      r_shift    <= w_shift;
    end
  end

  always_comb begin
    w_ustate  = r_ustate;
    w_cnt     = r_cnt;
    w_bitn    = r_bitn;
    w_shift   = r_shift;
    w_rx_stb  = 1'b0;
    w_rx_ferr = 1'b0;
    case (r_ustate)
      U_IDLE: begin
        if (r_rxd_prev && !w_rxd) begin
          w_ustate = U_START;
          w_cnt    = '0;
        end
      end
      U_START: begin
        if (r_cnt == c_half) begin
          w_cnt    = '0;
          w_bitn   = 3'd0;
          w_ustate = w_rxd ? U_IDLE : U_BITS;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      U_BITS: begin
        if (r_cnt == c_full) begin
          w_cnt   = '0;
          w_shift = {w_rxd, r_shift[7:1]};
          w_bitn  = r_bitn + 3'd1;
          if (r_bitn == 3'd7) w_ustate = U_STOP;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      U_STOP: begin
        if (r_cnt == c_full) begin
          w_cnt = '0;
          if (w_rxd) begin
            w_rx_stb = 1'b1;
            w_ustate = U_IDLE;
          end else begin
            w_rx_ferr = 1'b1;
            w_ustate  = U_WAIT;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      U_WAIT:  if (w_rxd) w_ustate = U_IDLE;
      default: w_ustate = U_IDLE;
    endcase
  end

  // ---------------- COBS decoder and lookahead ----------------
  typedef enum logic [1:0] {D_SYNC, D_CODE, D_DATA, D_DISCARD} dec_state_t;
  dec_state_t       r_dstate, w_dstate;
  logic [7:0]       r_rem, w_rem;
  logic             r_zpend, w_zpend;
  logic [IDX_W:0]   r_count, w_count;
  logic             r_hold_full, w_hold_full;
  logic [7:0]       r_hold_data, w_hold_data;
  logic             w_decode;
  logic [7:0]       w_dbyte;
  logic [IDX_W:0]   w_prev_idx;
  logic             r_valid, w_valid, r_first, w_first, r_last, w_last;
  logic             r_ok, w_ok, r_err, w_err;
  logic [7:0]       r_data, w_data;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [IDX_W:0]   r_len, w_len;
  logic [1:0]       r_code, w_code;

  // Held byte sits at position count-1 of the frame.
  assign w_prev_idx = r_count - 1'b1;

  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      r_dstate    <= D_SYNC;
      r_rem       <= 8'h00;
      r_zpend     <= 1'b0;
      r_count     <= '0;
      r_hold_full <= 1'b0;
      r_hold_data <= 8'h00;
      r_valid     <= 1'b0;
      r_data      <= 8'h00;
      r_idx       <= '0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_ok        <= 1'b0;
      r_len       <= '0;
      r_err       <= 1'b0;
      r_code      <= 2'd0;
    end else begin
      r_dstate    <= w_dstate;
      r_rem       <= w_rem;
      r_zpend     <= w_zpend;
      r_count     <= w_count;
      r_hold_full <= w_hold_full;
      r_hold_data <= w_hold_data;
      r_valid     <= w_valid;
      r_data      <= w_data;
      r_idx       <= w_idx;
      r_first     <= w_first;
      r_last      <= w_last;
      r_ok        <= w_ok;
      r_len       <= w_len;
      r_err       <= w_err;
      r_code      <= w_code;
    end
  end

  always_comb begin
    w_dstate    = r_dstate;
    w_rem       = r_rem;
    w_zpend     = r_zpend;
    w_count     = r_count;
    w_hold_full = r_hold_full;
    w_hold_data = r_hold_data;
    w_decode    = 1'b0;
    w_dbyte     = 8'h00;
    w_valid     = 1'b0;
    w_data      = 8'h00;
    w_idx       = '0;
    w_first     = 1'b0;
    w_last      = 1'b0;
    w_ok        = 1'b0;
    w_len       = '0;
    w_err       = 1'b0;
    w_code      = 2'd0;
    if (w_rx_ferr) begin
      if (r_dstate == D_CODE || r_dstate == D_DATA) begin
        w_err       = 1'b1;
        w_code      = 2'd3;
        w_dstate    = D_DISCARD;
        w_hold_full = 1'b0;
        w_count     = '0;
      end
    end else if (w_rx_stb) begin
      case (r_dstate)
        D_SYNC: if (r_shift == 8'h00) w_dstate = D_CODE;
        D_CODE: begin
          if (r_shift != 8'h00) begin
            w_rem    = r_shift - 8'd1;
            w_zpend  = (r_shift != 8'hFF);
            w_dstate = D_DATA;
          end
        end
        D_DATA: begin
          if (r_shift == 8'h00) begin
            if (r_rem == 8'h00) begin
              w_valid = r_hold_full;
              w_data  = r_hold_data;
              w_idx   = w_prev_idx[IDX_W-1:0];
              w_first = r_hold_full && (w_prev_idx == '0);
              w_last  = r_hold_full;
              w_ok    = 1'b1;
              w_len   = r_count;
            end else begin
              w_err  = 1'b1;
              w_code = 2'd1;
            end
            w_dstate    = D_CODE;
            w_hold_full = 1'b0;
            w_count     = '0;
          end else if (r_rem != 8'h00) begin
            w_decode = 1'b1;
            w_dbyte  = r_shift;
            w_rem    = r_rem - 8'd1;
          end else begin
            // Group boundary: the implicit zero only exists for codes below 0xFF.
            w_decode = r_zpend;
            w_rem    = r_shift - 8'd1;
            w_zpend  = (r_shift != 8'hFF);
          end
        end
        D_DISCARD: if (r_shift == 8'h00) w_dstate = D_CODE;
        default:   w_dstate = D_SYNC;
      endcase
    end
    if (w_decode) begin
      if (r_count == c_max) begin
        w_err       = 1'b1;
        w_code      = 2'd2;
        w_dstate    = D_DISCARD;
        w_hold_full = 1'b0;
        w_count     = '0;
      end else begin
        w_valid     = r_hold_full;
        w_data      = r_hold_data;
        w_idx       = w_prev_idx[IDX_W-1:0];
        w_first     = r_hold_full && (w_prev_idx == '0);
        w_hold_full = 1'b1;
        w_hold_data = w_dbyte;
        w_count     = r_count + 1'b1;
      end
    end
  end

  assign O_data     = r_data;
  assign O_valid    = r_valid;
  assign O_idx      = r_idx;
  assign O_first    = r_first;
  assign O_last     = r_last;
  assign O_frame_ok = r_ok;
  assign O_len      = r_len;
  assign O_err      = r_err;
  assign O_err_code = r_code;
endmodule
`default_nettype wire

// File: tb/tb_cobs_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cobs_uart_rx
// Brief    : Bench for cobs_uart_rx: frame vector table plus scoreboarded corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cobs_uart_rx;
  localparam int c_div = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd_a = 1'b1;
  logic rxd_b = 1'b1;

  logic [7:0] a_data, b_data;
  logic       a_valid, a_first, a_last, a_ok, a_err;
  logic       b_valid, b_first, b_last, b_ok, b_err;
  logic [7:0] a_idx;
  logic [8:0] a_len;
  logic [1:0] a_code, b_code;
  logic [1:0] b_idx;
  logic [2:0] b_len;

  always #5 clk = ~clk;

  cobs_uart_rx #(.CLK_HZ(1600), .BAUD(100), .MAX_FRAME(256)) dut_a (
    .I_clk(clk), .I_reset_n(rst_n), .rxd(rxd_a),
    .O_data(a_data), .O_valid(a_valid), .O_idx(a_idx), .O_first(a_first),
    .O_last(a_last), .O_frame_ok(a_ok), .O_len(a_len), .O_err(a_err),
    .O_err_code(a_code)
  );

  cobs_uart_rx #(.CLK_HZ(1600), .BAUD(100), .MAX_FRAME(4)) dut_b (
    .I_clk(clk), .I_reset_n(rst_n), .rxd(rxd_b),
    .O_data(b_data), .O_valid(b_valid), .O_idx(b_idx), .O_first(b_first),
    .O_last(b_last), .O_frame_ok(b_ok), .O_len(b_len), .O_err(b_err),
    .O_err_code(b_code)
  );

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic [7:0] idx;
    logic       first;
    logic       last;
    logic       ok;
    logic [8:0] len;
    logic       err;
    logic [1:0] code;
  } ev_t;

  typedef struct {
    int          tgt;
    int          n_in;
    logic [63:0] in_b;
    int          n_out;
    logic [63:0] out_b;
    logic        ok;
    logic [1:0]  code;
  } vec_t;

  ev_t qa[$];
  ev_t qb[$];
  int  checks = 0;
  int  failures = 0;
  vec_t tbl[9];

  function automatic ev_t mk_byte(input logic [7:0] d, input int idx, input logic last, input int len);
    ev_t e;
    e       = '0;
    e.valid = 1'b1;
    e.data  = d;
    e.idx   = 8'(idx);
    e.first = (idx == 0);
    e.last  = last;
    e.ok    = last;
    e.len   = last ? 9'(len) : 9'd0;
    return e;
  endfunction

  function automatic ev_t mk_err(input logic [1:0] c);
    ev_t e;
    e      = '0;
    e.err  = 1'b1;
    e.code = c;
    return e;
  endfunction

  // Only fields qualified by their strobe are compared.
  function automatic logic ev_match(input ev_t g, input ev_t x);
    if (g.valid !== x.valid || g.ok !== x.ok || g.err !== x.err) return 1'b0;
    if (x.valid && (g.data !== x.data || g.idx !== x.idx || g.first !== x.first || g.last !== x.last))
      return 1'b0;
    if (x.ok && g.len !== x.len) return 1'b0;
    if (x.err && g.code !== x.code) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int tgt, input ev_t e);
    if (tgt == 0) qa.push_back(e);
    else          qb.push_back(e);
  endtask

  task automatic check_ev(input int tgt, input ev_t g);
    ev_t x;
    checks++;
    if ((tgt == 0 && qa.size() == 0) || (tgt == 1 && qb.size() == 0)) begin
      failures++;
      $display("FAIL unexpected_event dut=%0d got=%h required=none", tgt, g);
    end else begin
      x = (tgt == 0) ? qa.pop_front() : qb.pop_front();
      if (!ev_match(g, x)) begin
        failures++;
        $display("FAIL event dut=%0d got=%h required=%h", tgt, g, x);
      end
    end
  endtask

  always @(negedge clk) begin
    if (a_valid || a_ok || a_err)
      check_ev(0, {a_valid, a_data, a_idx, a_first, a_last, a_ok, a_len, a_err, a_code});
  end

  always @(negedge clk) begin
    if (b_valid || b_ok || b_err)
      check_ev(1, {b_valid, b_data, 6'd0, b_idx, b_first, b_last, b_ok, 6'd0, b_len, b_err, b_code});
  end

  task automatic drive(input int tgt, input logic v);
    if (tgt == 0) rxd_a = v;
    else          rxd_b = v;
    repeat (c_div) @(negedge clk);
  endtask

  task automatic send_byte(input int tgt, input logic [7:0] b, input logic stop);
    drive(tgt, 1'b0);
    for (int i = 0; i < 8; i++) drive(tgt, b[i]);
    drive(tgt, stop);
    if (!stop) drive(tgt, 1'b1);
    if (tgt == 0) rxd_a = 1'b1;
    else          rxd_b = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    for (int i = 0; i < v.n_out; i++)
      push(v.tgt, mk_byte(v.out_b[8*(v.n_out-1-i) +: 8], i, v.ok && (i == v.n_out - 1), v.n_out));
    if (v.code != 2'd0) push(v.tgt, mk_err(v.code));
    for (int i = 0; i < v.n_in; i++)
      send_byte(v.tgt, v.in_b[8*(v.n_in-1-i) +: 8], 1'b1);
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if ({a_valid, a_first, a_last, a_ok, a_err, a_data, a_idx, a_len, a_code} !== '0 ||
        {b_valid, b_first, b_last, b_ok, b_err, b_data, b_idx, b_len, b_code} !== '0) begin
      failures++;
      $display("FAIL %s got_a=%b/%h got_b=%b/%h required=all zero", name,
               {a_valid, a_ok, a_err}, a_data, {b_valid, b_ok, b_err}, b_data);
    end
  endtask

  initial begin
    // Bytes listed first-on-the-wire at the most significant end.
    tbl[0] = '{0, 6, 64'h031122023300, 4, 64'h11220033, 1'b1, 2'd0};
    tbl[1] = '{0, 4, 64'h05112200,     1, 64'h11,       1'b0, 2'd1};
    tbl[2] = '{0, 3, 64'h02AA00,       1, 64'hAA,       1'b1, 2'd0};
    tbl[3] = '{0, 1, 64'h00,           0, 64'h0,        1'b0, 2'd0};
    tbl[4] = '{0, 3, 64'h010100,       1, 64'h00,       1'b1, 2'd0};
    tbl[5] = '{0, 4, 64'h02050100,     2, 64'h0500,     1'b1, 2'd0};
    tbl[6] = '{0, 2, 64'h0300,         0, 64'h0,        1'b0, 2'd1};
    tbl[7] = '{1, 7, 64'h06010203040500, 3, 64'h010203, 1'b0, 2'd2};
    tbl[8] = '{1, 6, 64'h050102030400, 4, 64'h01020304, 1'b1, 2'd0};

    repeat (4) @(negedge clk);
    check_quiet("reset_outputs");
    rst_n = 1'b1;

    // Bytes before the first delimiter must be ignored.
    send_byte(0, 8'h05, 1'b1);
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_byte(1, 8'h00, 1'b1);

    for (int k = 0; k < 9; k++) run_vec(tbl[k]);

    // A full 0xFF group has no trailing implicit zero.
    for (int i = 0; i < 254; i++) push(0, mk_byte(8'(i + 1), i, i == 253, 254));
    send_byte(0, 8'hFF, 1'b1);
    for (int i = 1; i <= 254; i++) send_byte(0, 8'(i), 1'b1);
    send_byte(0, 8'h00, 1'b1);

    // Framing error mid-frame, then resync on delimiter and decode cleanly.
    push(0, mk_err(2'd3));
    send_byte(0, 8'h02, 1'b1);
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h55, 1'b0);
    send_byte(0, 8'h00, 1'b1);
    push(0, mk_byte(8'hCC, 0, 1'b1, 1));
    send_byte(0, 8'h02, 1'b1);
    send_byte(0, 8'hCC, 1'b1);
    send_byte(0, 8'h00, 1'b1);

    // Reset pulse mid-frame: only a fresh delimiter reopens decoding.
    push(0, mk_byte(8'h11, 0, 1'b0, 0));
    send_byte(0, 8'h03, 1'b1);
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h22, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_quiet("midframe_reset_outputs");
    checks++;
    if (qa.size() != 0) begin
      failures++;
      $display("FAIL pre_reset_events pending=%0d required=0", qa.size());
    end
    send_byte(0, 8'h02, 1'b1);
    send_byte(0, 8'h33, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    push(0, mk_byte(8'h44, 0, 1'b1, 1));
    send_byte(0, 8'h02, 1'b1);
    send_byte(0, 8'h44, 1'b1);
    send_byte(0, 8'h00, 1'b1);

    // A short low glitch must not start a byte.
    rxd_a = 1'b0;
    repeat (5) @(negedge clk);
    rxd_a = 1'b1;
    repeat (30 * c_div) @(negedge clk);
    push(0, mk_byte(8'hBB, 0, 1'b1, 1));
    send_byte(0, 8'h02, 1'b1);
    send_byte(0, 8'hBB, 1'b1);
    send_byte(0, 8'h00, 1'b1);

    repeat (30 * c_div) @(negedge clk);
    checks++;
    if (qa.size() != 0) begin
      failures++;
      $display("FAIL missing_events dut=0 pending=%0d required=0", qa.size());
    end
    checks++;
    if (qb.size() != 0) begin
      failures++;
      $display("FAIL missing_events dut=1 pending=%0d required=0", qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
